instr_fetch_mem: RTL
====================

INSTR_FETCH_MEM -- requirements
Module: instr_fetch_mem

Interface
REQ-001 SHALL have parameter SIZE, default 1024, memory size in bytes (multiple of 4, at least 8).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, wait states per fetch (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have port req_valid  input  1  fetch request present.
REQ-006 SHALL have port req_ready  output  1  block can accept a request.
REQ-007 SHALL have port req_addr  input  64  byte address of the requested instruction.
REQ-008 SHALL have port rsp_valid  output  1  response present.
REQ-009 SHALL have port rsp_ready  input  1  consumer accepts the response.
REQ-010 SHALL have port rsp_instr  output  32  fetched word, little-endian: byte at A goes to [7:0] and byte at A+3 goes to [31:24].
REQ-011 SHALL have port rsp_fault  output  1  request was misaligned or out of range.
REQ-012 SHALL have port load_en  input  1  program-load byte write strobe.
REQ-013 SHALL have port load_addr  input  64  byte address for the load write.
REQ-014 SHALL have port load_data  input  8  byte to write.

Function
REQ-015 SHALL hold the memory as SIZE bytes, zero at time 0, and reset SHALL NOT clear it.
REQ-016 SHALL implement states IDLE, WAIT and RESP; req_ready SHALL be 1 only in IDLE.
REQ-017 SHALL accept a request on a cycle where req_valid and req_ready are both 1, capturing req_addr.
REQ-018 SHALL treat an accepted request as a fault when req_addr[1:0] is not 0 or req_addr+3 is at least SIZE; address compare SHALL be full 64-bit, with no wrap.
REQ-019 On a fault, the block SHALL move IDLE->RESP with rsp_fault=1 and rsp_instr=0; rsp_valid SHALL rise on the cycle after acceptance.
REQ-020 For a non-fault request with WAIT_CYCLES=0, the block SHALL move IDLE->RESP; otherwise it SHALL move IDLE->WAIT, load a counter with WAIT_CYCLES, and go WAIT->RESP when the counter reaches 1, decrementing each cycle.
REQ-021 Non-fault latency SHALL be: accept at cycle N, rsp_valid=1 at cycle N+1+WAIT_CYCLES.
REQ-022 SHALL sample the memory word on the cycle the FSM enters RESP; load writes on or before that edge SHALL be visible in rsp_instr.
REQ-023 In RESP, rsp_valid, rsp_instr and rsp_fault SHALL be held stable until rsp_ready=1, then the block SHALL return to IDLE on that edge.
REQ-024 SHALL NOT accept a new request in the cycle the response is consumed; back-to-back throughput is one fetch per 2+WAIT_CYCLES cycles.
REQ-025 SHALL write load_data to memory at load_addr when load_en=1 in any state; a write with load_addr at least SIZE SHALL be ignored.
REQ-026 When a load write and a response sample hit the same byte on the same edge, the sample SHALL see the new byte.

Reset
REQ-027 While rst_n=0, the FSM SHALL be IDLE and SHALL drive req_ready=1, rsp_valid=0, rsp_fault=0, rsp_instr=0, counter=0.
REQ-028 Reset asserted mid-fetch (WAIT or RESP) SHALL drop the in-flight request with no response after release.

Configuration
REQ-029 With IMEM_PREFETCH_EN defined, each non-fault sample at A SHALL also capture the word at A+4 into a one-entry buffer, if A+4+3 is less than SIZE.
REQ-030 With IMEM_PREFETCH_EN defined, a later request whose address matches a valid buffer entry SHALL go IDLE->RESP with no wait states and return the buffered word.
REQ-031 With IMEM_PREFETCH_EN defined, any load_en write, reset, or fault SHALL invalidate the buffer.
REQ-032 Without IMEM_PREFETCH_EN, the block SHALL contain no buffer and SHALL use the REQ-021 latency for every fetch.

Verification
REQ-033 Bench SHALL cover: load bytes E5,03,1F,8B at 0..3; WAIT_CYCLES=2; request 0 accepted at cycle 10 -> rsp_valid at cycle 13, rsp_instr=0x8B1F03E5, rsp_fault=0.
REQ-034 Bench SHALL cover: request addr 2 -> rsp_valid on the next cycle, rsp_fault=1, rsp_instr=0; request addr 1024 with SIZE=1024 -> fault.
REQ-035 Bench SHALL cover: hold rsp_ready=0 for 5 cycles in RESP -> outputs stable and req_ready=0 throughout; rsp_ready=1 -> req_ready=1 on the next cycle.
REQ-036 Bench SHALL cover: load 0xA4 to byte 16 while a fetch of 16 is in WAIT -> rsp_instr[7:0]=0xA4.
REQ-037 Bench SHALL cover: pull rst_n low during WAIT -> rsp_valid=0 immediately, req_ready=1, and no response after release.
REQ-038 Bench SHALL cover, with IMEM_PREFETCH_EN: fetch 0 then fetch 4 -> second rsp_valid one cycle after acceptance; insert a load_en between them -> full WAIT_CYCLES latency.

Source files
------------

// File: rtl/instr_fetch_mem.sv
// instr_fetch_mem: byte-loadable instruction memory with a valid/ready fetch port and fixed wait states.
// Defining IMEM_PREFETCH_EN adds a one-word next-line buffer that serves sequential fetches without wait states.
module instr_fetch_mem #(
  parameter int SIZE        = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_instr,
  output logic        rsp_fault,
  input  logic        load_en,
  input  logic [63:0] load_addr,
  input  logic [7:0]  load_data
);

  localparam int          AW     = $clog2(SIZE);
  localparam logic [63:0] SIZE64 = 64'(SIZE);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  logic [7:0]  r_mem [SIZE] = '{default: 8'h00};
  state_t      r_state;
  logic [3:0]  r_count;
  logic [63:0] r_addr;
  logic        r_rspValid;
  logic        r_rspFault;
  logic [31:0] r_rspInstr;

  logic        w_reqFault;
  logic [63:0] w_sAddr;
  logic [31:0] w_word;

  // A load landing on the same edge as a sample is forwarded so the response sees the new byte.
  function automatic logic [31:0] readWord(input logic [63:0] a);
    logic [63:0] b;
    readWord = '0;
    for (int k = 0; k < 4; k++) begin
      b = a + 64'(k);
      readWord[8*k +: 8] = (load_en && load_addr == b) ? load_data : r_mem[b[AW-1:0]];
    end
  endfunction

  assign w_reqFault = (req_addr[1:0] != 2'b00) || (req_addr > SIZE64 - 64'd4);
  assign w_sAddr    = (r_state == IDLE) ? req_addr : r_addr;
  assign w_word     = readWord(w_sAddr);

  assign req_ready = (r_state == IDLE);
  assign rsp_valid = r_rspValid;
  assign rsp_instr = r_rspInstr;
  assign rsp_fault = r_rspFault;

  always_ff @(posedge clk) begin
    if (load_en && load_addr < SIZE64) begin
      r_mem[load_addr[AW-1:0]] <= load_data;
    end
  end

`ifdef IMEM_PREFETCH_EN
  logic        r_pfValid;
  logic [63:0] r_pfAddr;
  logic [31:0] r_pfData;
  logic        w_pfHit;
  logic        w_sample;
  logic        w_nextOk;
  logic [31:0] w_nextWord;

  assign w_pfHit    = r_pfValid && !load_en && (req_addr == r_pfAddr);
  assign w_nextOk   = (w_sAddr <= SIZE64 - 64'd8);
  assign w_nextWord = readWord(w_sAddr + 64'd4);
  assign w_sample   = (r_state == IDLE && req_valid && !w_reqFault && (w_pfHit || WAIT_CYCLES == 0))
                   || (r_state == WAIT && r_count == 4'd1);

  // Any program load may alter the buffered word, so it always wins over a refill.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pfValid <= 1'b0;
      r_pfAddr  <= '0;
      r_pfData  <= '0;
    end else if (load_en) begin
      r_pfValid <= 1'b0;
    end else if (r_state == IDLE && req_valid && w_reqFault) begin
      r_pfValid <= 1'b0;
    end else if (w_sample) begin
      r_pfValid <= w_nextOk;
      r_pfAddr  <= w_sAddr + 64'd4;
      r_pfData  <= w_nextWord;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_addr     <= '0;
      r_rspValid <= 1'b0;
      r_rspFault <= 1'b0;
      r_rspInstr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (req_valid) begin
            r_addr <= req_addr;
            if (w_reqFault) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspFault <= 1'b1;
              r_rspInstr <= '0;
            end
`ifdef IMEM_PREFETCH_EN
            else if (w_pfHit) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspFault <= 1'b0;
              r_rspInstr <= r_pfData;
            end
`endif
            else if (WAIT_CYCLES == 0) begin
              r_state    <= RESP;
              r_rspValid <= 1'b1;
              r_rspFault <= 1'b0;
              r_rspInstr <= w_word;
            end else begin
              r_state <= WAIT;
              r_count <= 4'(WAIT_CYCLES);
            end
          end
        end
        WAIT: begin
          if (r_count == 4'd1) begin
            r_state    <= RESP;
            r_count    <= '0;
            r_rspValid <= 1'b1;
            r_rspFault <= 1'b0;
            r_rspInstr <= w_word;
          end else begin
            r_count <= r_count - 4'd1;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            r_state    <= IDLE;
            r_rspValid <= 1'b0;
            r_rspFault <= 1'b0;
            r_rspInstr <= '0;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
